pair_line_printer: RTL and testbench
====================================

Name: pair_line_printer

Overview:
Downstream consumer of the transformer stage. Accepts one line's stream of (lhs, rhs) character pairs over a valid/ready handshake and prints it on a UART TX pin in this format: all lhs chars, separator " => ", all rhs chars, then CR LF. lhs chars are transmitted as they arrive. rhs chars are buffered in a small FIFO until the lhs half of the line is complete. Sits between the transformer's char outputs and the chip's serial output pin.

Parameters:
CLK_DIV, 104, clk cycles per UART bit (8N1); minimum 2
RHS_DEPTH, 32, rhs FIFO depth in bytes; power of two

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse that begins printing a line; sampled only in IDLE
line_empty  in  1  sampled with start; 1 = zero-length line (print CR LF only)
pair_valid  in  1  lhs/rhs/pair_last are valid
pair_ready  out  1  printer accepts the pair this cycle
lhs  in  8  input-side ASCII char
rhs  in  8  transformed ASCII char
pair_last  in  1  marks the final pair of the line
tx  out  1  UART serial output; idle high
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the LF stop bit completes
overflow  out  1  sticky; an rhs byte was dropped because the FIFO was full; cleared on accepted start or rst

Behaviour:
- Reset (synchronous, rst=1 at posedge) forces: state IDLE; tx=1; pair_ready=0; busy=0; done=0; overflow=0; FIFO emptied; UART idle. This applies mid-frame too: tx is 1 after the next edge and no partial byte is resumed.
- UART: 8N1, LSB first; start bit 0, 8 data bits, stop bit 1; each bit held exactly CLK_DIV cycles, so one byte = 10*CLK_DIV cycles. A byte load in cycle N drives the start bit from cycle N+1. The next byte may load in the cycle the stop bit ends, giving back-to-back frames with no idle gap.
- Char sanitising, applied to every lhs/rhs byte when it is sent: byte <8'h20 or >8'h7E is replaced by '?' (8'h3F). Separator, CR and LF bytes are not sanitised.
- FSM states: IDLE, LHS, SEP, RHS, CR, LF, FIN.
- IDLE: start=1 -> busy=1, overflow cleared, FIFO cleared. Next state is CR if line_empty=1, else LHS. start in any other state is ignored.
- LHS: pair_ready = UART idle-or-finishing-stop-bit. On handshake (pair_valid & pair_ready): lhs byte is loaded into the UART. rhs is pushed to the FIFO; if the FIFO is full, rhs is dropped and overflow is set. If pair_last=1, next state is SEP.
- pair_ready is 0 in every state except LHS. Upstream holds its data while ready=0.
- SEP: sends 8'h20, 8'h3D, 8'h3E, 8'h20 in order, then RHS.
- RHS: pops and sends FIFO bytes in order until the FIFO is empty, then CR. An empty FIFO goes straight to CR.
- CR: sends 8'h0D. LF: sends 8'h0A. FIN: waits for the LF stop bit to finish, pulses done for 1 cycle, sets busy=0, returns to IDLE. A start in the same cycle as done is ignored.
- FIFO: read/write pointers are log2(RHS_DEPTH)+1 bits wide. Full when the low bits are equal and the MSBs differ; empty when the pointers are equal. Pointers wrap modulo 2*RHS_DEPTH. No simultaneous push and pop occurs, because pushes happen only in LHS and pops only in RHS.
- pair_last on the first handshake gives a line of length 1.

Decomposition:
- Package printer_pkg: FSM state enum; separator byte constants (SEP0..SEP3); CR/LF/'?' constants; printable bounds 8'h20/8'h7E.
- Sub-module uart_tx_8n1 (params CLK_DIV): ports clk, rst, load, data[7:0], tx, idle. idle is high when a byte may load this cycle.
- The FIFO is inline in pair_line_printer.

Test Plan:
- Line "ab"/"xy" with CLK_DIV=4: pairs (a,x), (b,y last) -> tx decodes "ab => xy\r\n" (10 bytes). done pulses once at 10*10*4 cycles after the first byte load, within ±1 cycle. overflow=0.
- start with line_empty=1 -> tx decodes exactly "\r\n". pair_ready stays 0 throughout. done pulses once.
- 33 pairs with RHS_DEPTH=32 -> first 32 rhs bytes are printed in order and the 33rd is dropped. overflow=1 after the 33rd handshake and stays 1 until the next start.
- lhs=8'h00, rhs=8'h7F single pair -> tx decodes "? => ?\r\n".
- rst asserted during the SEP start bit -> tx=1 the following cycle, busy=0, pair_ready=0. A fresh start then prints a full correct line.
- start pulsed while busy, plus pair_valid held high with pair_ready low -> start is ignored, and no pair is consumed while pair_ready=0 (scoreboard byte count matches).

Source files
------------

// File: rtl/printer_pkg.sv
// Shared types and byte constants for the pair line printer.
package printer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LHS,
        SEP,
        RHS,
        CR,
        LF,
        FIN
    } state_t;

    // " => " separator, sent verbatim between the two halves of a line
    localparam logic [7:0] SEP0 = 8'h20;
    localparam logic [7:0] SEP1 = 8'h3D;
    localparam logic [7:0] SEP2 = 8'h3E;
    localparam logic [7:0] SEP3 = 8'h20;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_SUB  = 8'h3F;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    // Replace anything outside printable ASCII with '?'
    function automatic logic [7:0] sanitize(input logic [7:0] c);
        return ((c < PRINT_MIN) || (c > PRINT_MAX)) ? CHAR_SUB : c;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter, LSB first, CLK_DIV clocks per bit.
// idle is also high in the final cycle of a stop bit so frames can be chained.
module uart_tx_8n1 #(
    parameter int CLK_DIV = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       idle
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic             active;
    logic [9:0]       shreg;
    logic [3:0]       bit_idx;
    logic [DIV_W-1:0] div_cnt;
    logic             bit_end;
    logic             frame_end;

    assign bit_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign frame_end = bit_end && (bit_idx == 4'd9);
    assign idle      = !active || frame_end;
    assign tx        = active ? shreg[0] : 1'b1;

    // Frame sequencer: load start/data/stop into a shift register, step one bit per CLK_DIV clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            shreg   <= '1;
            bit_idx <= 4'd0;
            div_cnt <= '0;
        end else if (load && idle) begin
            active  <= 1'b1;
            shreg   <= {1'b1, data, 1'b0};
            bit_idx <= 4'd0;
            div_cnt <= '0;
        end else if (active) begin
            if (bit_end) begin
                div_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    shreg   <= {1'b1, shreg[9:1]};
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pair_line_printer.sv
// Prints one line of (lhs, rhs) pairs on a UART as "<lhs> => <rhs>\r\n".
// lhs bytes go straight out; rhs bytes wait in a small FIFO until the lhs half is done.
module pair_line_printer
    import printer_pkg::*;
#(
    parameter int CLK_DIV   = 104,
    parameter int RHS_DEPTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       line_empty,
    input  logic       pair_valid,
    output logic       pair_ready,
    input  logic [7:0] lhs,
    input  logic [7:0] rhs,
    input  logic       pair_last,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    localparam int AW = $clog2(RHS_DEPTH);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  sep_idx;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  fifo_mem [RHS_DEPTH];
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        uart_load;
    logic        uart_idle;
    logic [7:0]  uart_data;
    logic        accept_start;

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign busy         = (state != IDLE);
    assign accept_start = (state == IDLE) && start;

    uart_tx_8n1 #(
        .CLK_DIV(CLK_DIV)
    ) u_uart (
        .clk (clk),
        .rst (rst),
        .load(uart_load),
        .data(uart_data),
        .tx  (tx),
        .idle(uart_idle)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, UART byte selection and handshake/done outputs
    always_comb begin
        state_nx   = state;
        uart_load  = 1'b0;
        uart_data  = 8'h00;
        pair_ready = 1'b0;
        done       = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = line_empty ? CR : LHS;
            end
            LHS: begin
                pair_ready = uart_idle;
                if (pair_valid && uart_idle) begin
                    uart_load = 1'b1;
                    uart_data = sanitize(lhs);
                    push      = 1'b1;
                    if (pair_last) state_nx = SEP;
                end
            end
            SEP: begin
                if (uart_idle) begin
                    uart_load = 1'b1;
                    case (sep_idx)
                        2'd0:    uart_data = SEP0;
                        2'd1:    uart_data = SEP1;
                        2'd2:    uart_data = SEP2;
                        default: uart_data = SEP3;
                    endcase
                    if (sep_idx == 2'd3) state_nx = RHS;
                end
            end
            RHS: begin
                if (fifo_empty) begin
                    state_nx = CR;
                end else if (uart_idle) begin
                    uart_load = 1'b1;
                    uart_data = sanitize(fifo_mem[rd_ptr[AW-1:0]]);
                    pop       = 1'b1;
                end
            end
            CR: begin
                if (uart_idle) begin
                    uart_load = 1'b1;
                    uart_data = CHAR_CR;
                    state_nx  = LF;
                end
            end
            LF: begin
                if (uart_idle) begin
                    uart_load = 1'b1;
                    uart_data = CHAR_LF;
                    state_nx  = FIN;
                end
            end
            FIN: begin
                if (uart_idle) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FIFO pointers, separator index and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sep_idx  <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (accept_start) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                sep_idx  <= 2'd0;
                overflow <= 1'b0;
            end
            if (push) begin
                if (fifo_full) overflow <= 1'b1;
                else           wr_ptr   <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if ((state == SEP) && uart_idle) sep_idx <= sep_idx + 2'd1;
        end
    end

    // FIFO storage, written only when there is room
    always_ff @(posedge clk) begin
        if (push && !fifo_full) fifo_mem[wr_ptr[AW-1:0]] <= rhs;
    end

endmodule

// File: tb/tb_pair_line_printer.sv
// Self-checking bench for pair_line_printer: drives lines of pairs, decodes tx
// and compares against an expected string built straight from the line contents.
`timescale 1ns/1ps
module tb_pair_line_printer;

    localparam int CLK_DIV   = 4;
    localparam int RHS_DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       line_empty;
    logic       pair_valid;
    logic       pair_ready;
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic       pair_last;
    logic       tx;
    logic       busy;
    logic       done;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_total  = 0;
    int hs_total    = 0;
    int ready_total = 0;
    int frame_err   = 0;
    int load_cyc    = 0;
    int done_cyc    = 0;

    logic [7:0] rx_q[$];
    logic [7:0] line_lhs[$];
    logic [7:0] line_rhs[$];

    always #5 clk = ~clk;

    pair_line_printer #(
        .CLK_DIV  (CLK_DIV),
        .RHS_DEPTH(RHS_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .line_empty(line_empty),
        .pair_valid(pair_valid),
        .pair_ready(pair_ready),
        .lhs       (lhs),
        .rhs       (rhs),
        .pair_last (pair_last),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    // Cycle counter and handshake counter
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && pair_valid && pair_ready) hs_total <= hs_total + 1;
    end

    // Done pulses and cycles with ready high
    always @(negedge clk) begin
        if (done)       done_total  <= done_total + 1;
        if (pair_ready) ready_total <= ready_total + 1;
    end

    // UART receiver: sample each bit at its centre on falling clock edges
    initial begin : rx_decoder
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && tx === 1'b0) begin
                repeat (CLK_DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_char(input logic [7:0] c);
        if (c >= 8'd32 && c <= 8'd126) return c;
        return 8'h3F;
    endfunction

    task automatic gen_line(input int n);
        line_lhs.delete();
        line_rhs.delete();
        for (int i = 0; i < n; i++) begin
            line_lhs.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(32, 126)));
            line_rhs.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(32, 126)));
        end
    endtask

    // mode 0: plain line; 1: stray start pulses and held pair_valid; 2: reset in first separator start bit
    task automatic applyStimulus(input bit empty_line, input int mode);
        int k;
        int guard;
        int hs_base;
        int done_base;
        rx_q.delete();
        frame_err = 0;
        hs_base   = hs_total;
        done_base = done_total;
        @(negedge clk);
        start      = 1'b1;
        line_empty = empty_line;
        @(negedge clk);
        start      = 1'b0;
        line_empty = 1'b0;
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);
        k = 0;
        guard = 0;
        while (!empty_line && k < line_lhs.size() && guard < 5000) begin
            pair_valid = 1'b1;
            lhs        = line_lhs[k];
            rhs        = line_rhs[k];
            pair_last  = (k == line_lhs.size() - 1);
            if (pair_ready) begin
                if (k == 0) load_cyc = cyc;
                @(negedge clk);
                k++;
                checkOutput($sformatf("ovf_after_pair%0d", k), {31'd0, overflow}, (k > RHS_DEPTH) ? 32'd1 : 32'd0);
            end else begin
                @(negedge clk);
                guard++;
            end
        end
        if (guard >= 5000) checkOutput("pair_timeout", 32'd1, 32'd0);
        if (mode == 1) begin
            pair_valid = 1'b1;
            lhs        = 8'h41;
            rhs        = 8'h42;
            pair_last  = 1'b1;
        end else begin
            pair_valid = 1'b0;
            pair_last  = 1'b0;
        end
        if (mode == 2) begin
            while (cyc < load_cyc + 42) @(negedge clk);
            checkOutput("sep_start_bit_low", {31'd0, tx}, 32'd0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checkOutput("rst_tx", {31'd0, tx}, 32'd1);
            checkOutput("rst_busy", {31'd0, busy}, 32'd0);
            checkOutput("rst_ready", {31'd0, pair_ready}, 32'd0);
            checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
            return;
        end
        guard = 0;
        while (!done && guard < 20000) begin
            if (mode == 1 && (guard == 20 || guard == 200)) begin
                start      = 1'b1;
                line_empty = 1'b1;
            end else begin
                start      = 1'b0;
                line_empty = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        if (!done) checkOutput("done_timeout", 32'd1, 32'd0);
        done_cyc = cyc;
        // a start coinciding with done must be ignored
        if (mode == 1) begin
            start      = 1'b1;
            line_empty = 1'b1;
        end else begin
            start      = 1'b0;
            line_empty = 1'b0;
        end
        @(negedge clk);
        start      = 1'b0;
        line_empty = 1'b0;
        pair_valid = 1'b0;
        pair_last  = 1'b0;
        checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("done_pulses", done_total - done_base, 32'd1);
        checkOutput("handshakes", hs_total - hs_base, empty_line ? 32'd0 : line_lhs.size());
    endtask

    task automatic checkLine(input string name, input bit empty_line);
        logic [7:0] exp[$];
        int nr;
        if (!empty_line) begin
            foreach (line_lhs[i]) exp.push_back(model_char(line_lhs[i]));
            exp.push_back(8'h20);
            exp.push_back(8'h3D);
            exp.push_back(8'h3E);
            exp.push_back(8'h20);
            nr = (line_rhs.size() < RHS_DEPTH) ? line_rhs.size() : RHS_DEPTH;
            for (int i = 0; i < nr; i++) exp.push_back(model_char(line_rhs[i]));
        end
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
        checkOutput({name, "_len"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            checkOutput($sformatf("%s_byte%0d", name, i), {24'd0, rx_q[i]}, {24'd0, exp[i]});
        checkOutput({name, "_framing"}, frame_err, 32'd0);
    endtask

    initial begin : main
        int rb;
        rst        = 1'b1;
        start      = 1'b0;
        line_empty = 1'b0;
        pair_valid = 1'b0;
        lhs        = 8'h00;
        rhs        = 8'h00;
        pair_last  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_ready", {31'd0, pair_ready}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] line ab/xy");
        line_lhs = '{8'h61, 8'h62};
        line_rhs = '{8'h78, 8'h79};
        applyStimulus(1'b0, 0);
        checkLine("ab", 1'b0);
        checkOutput("ab_done_latency", ((done_cyc - load_cyc >= 399) && (done_cyc - load_cyc <= 401)) ? 32'd1 : 32'd0, 32'd1);
        checkOutput("ab_ovf", {31'd0, overflow}, 32'd0);

        $display("[TB] empty line");
        rb = ready_total;
        applyStimulus(1'b1, 0);
        checkLine("empty", 1'b1);
        checkOutput("empty_ready_cycles", ready_total - rb, 32'd0);

        $display("[TB] 33 pairs");
        gen_line(33);
        applyStimulus(1'b0, 0);
        checkLine("ovf33", 1'b0);
        checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);

        $display("[TB] unprintable chars");
        line_lhs = '{8'h00};
        line_rhs = '{8'h7F};
        applyStimulus(1'b0, 0);
        checkLine("subst", 1'b0);

        $display("[TB] reset mid separator");
        gen_line(1);
        applyStimulus(1'b0, 2);
        repeat (60) @(negedge clk);
        gen_line(5);
        applyStimulus(1'b0, 0);
        checkLine("after_rst", 1'b0);

        $display("[TB] start while busy");
        gen_line(6);
        applyStimulus(1'b0, 1);
        checkLine("poke", 1'b0);

        for (int r = 0; r < 5; r++) begin
            gen_line($urandom_range(1, 40));
            applyStimulus(1'b0, 0);
            checkLine($sformatf("rand%0d", r), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
